// File: rtl/huff_decoder_pkg.sv
// Shared types and constants for the Huffman decoder.
// Optional feature macro: HUFF_DEC_ERR_EN (adds the sticky ERR state).
package huff_pkg;

  localparam int unsigned NSYM   = 6;
  localparam int unsigned MAXLEN = 7;
  localparam int unsigned SYM_W  = 3;
  localparam int unsigned LEN_W  = 3;

  typedef logic [SYM_W-1:0]  sym_t;
  typedef logic [LEN_W-1:0]  len_t;
  typedef logic [MAXLEN-1:0] code_t;

  typedef struct packed {
    code_t code;
    len_t  len;
  } entry_t;

  typedef enum logic [2:0] {
    StLoad,
    StShift,
    StCheck,
    StEmit,
    StDone
`ifdef HUFF_DEC_ERR_EN
    , StErr
`endif
  } state_e;

  // Ones in the low 'len' bit positions.
  function automatic code_t len_mask(len_t len);
    code_t m;
    m = '0;
    for (int i = 0; i < int'(MAXLEN); i++) begin
      if (i < int'(len)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/huff_decoder_if.sv
// Table-load, serial-bit and symbol-output signals of the Huffman decoder.
interface huff_decoder_if;
  import huff_pkg::*;

  logic  tbl_valid;
  sym_t  tbl_idx;
  code_t tbl_code;
  len_t  tbl_len;
  logic  tbl_done;
  logic  bit_valid;
  logic  bit_in;
  logic  bit_last;
  logic  bit_ready;
  logic  sym_valid;
  sym_t  sym_out;
  logic  dec_done;
  logic  err;

  modport master (
    output tbl_valid, tbl_idx, tbl_code, tbl_len, tbl_done, bit_valid, bit_in, bit_last,
    input  bit_ready, sym_valid, sym_out, dec_done, err
  );

  modport slave (
    input  tbl_valid, tbl_idx, tbl_code, tbl_len, tbl_done, bit_valid, bit_in, bit_last,
    output bit_ready, sym_valid, sym_out, dec_done, err
  );
endinterface

// File: rtl/huff_decoder_match.sv
// Combinational codeword lookup: compares the shift register against every
// table entry of the same length; lowest symbol index wins on ties.
module huff_match
  import huff_pkg::*;
(
  input  code_t                 sr,
  input  len_t                  cnt,
  input  entry_t [NSYM-1:0]     tbl,
  output logic                  hit,
  output sym_t                  idx
);

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = int'(NSYM) - 1; i >= 0; i--) begin
      if (tbl[i].len != '0 && tbl[i].len == cnt &&
          ((tbl[i].code ^ sr) & len_mask(cnt)) == '0) begin
        hit = 1'b1;
        idx = SYM_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/huff_decoder.sv
// Huffman decoder top: loads a code table, then decodes a serial MSB-first
// bitstream into symbol indices, two cycles per bit.
// Optional feature macro: HUFF_DEC_ERR_EN (unmatched stream -> sticky err).
module huff_decoder
  import huff_pkg::*;
(
  input logic           clk,
  input logic           reset,
  huff_decoder_if.slave bus
);

  state_e            state_q, state_d;
  entry_t [NSYM-1:0] tbl_q, tbl_d;
  code_t             sr_q, sr_d;
  len_t              cnt_q, cnt_d;
  logic              last_q, last_d;
  sym_t              sym_q, sym_d;
  logic              hit;
  sym_t              hit_idx;
  sym_t              wr_idx;

  assign wr_idx = bus.tbl_idx - SYM_W'(1);

  huff_match u_match (
    .sr  (sr_q),
    .cnt (cnt_q),
    .tbl (tbl_q),
    .hit (hit),
    .idx (hit_idx)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    tbl_d   = tbl_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sym_d   = sym_q;
    case (state_q)
      StLoad: begin
        if (bus.tbl_valid && bus.tbl_idx != '0 && bus.tbl_idx <= SYM_W'(NSYM)) begin
          tbl_d[wr_idx].code = bus.tbl_code;
          tbl_d[wr_idx].len  = bus.tbl_len;
        end
        if (bus.tbl_done) state_d = StShift;
      end
      StShift: begin
        if (bus.bit_valid) begin
          sr_d    = {sr_q[MAXLEN-2:0], bus.bit_in};
          cnt_d   = cnt_q + LEN_W'(1);
          last_d  = bus.bit_last;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (hit) begin
          sym_d   = hit_idx;
          sr_d    = '0;
          cnt_d   = '0;
          state_d = StEmit;
        end else if (cnt_q < LEN_W'(MAXLEN) && !last_q) begin
          state_d = StShift;
        end else begin
`ifdef HUFF_DEC_ERR_EN
          state_d = StErr;
`else
          // Drop the unmatched bits and carry on.
          sr_d    = '0;
          cnt_d   = '0;
          state_d = last_q ? StDone : StShift;
`endif
        end
      end
      StEmit: begin
        state_d = last_q ? StDone : StShift;
      end
      StDone: begin
        tbl_d   = '0;
        last_d  = 1'b0;
        state_d = StLoad;
      end
`ifdef HUFF_DEC_ERR_EN
      StErr: begin
        state_d = StErr;
      end
`endif
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoad;
      tbl_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sym_q   <= sym_d;
    end
  end

  assign bus.bit_ready = (state_q == StShift);
  assign bus.sym_valid = (state_q == StEmit);
  assign bus.dec_done  = (state_q == StDone);
  assign bus.sym_out   = sym_q;
`ifdef HUFF_DEC_ERR_EN
  assign bus.err       = (state_q == StErr);
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_huff_decoder.sv
// Directed self-checking bench for huff_decoder.
// Table: A1=1/1, A2=01/2, A3=000/3, A4=0011/4, A5=00101/5, A6=00100/5.
module tb_huff_decoder;
  import huff_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  huff_decoder_if bus ();

  huff_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  int mon_sym[$];
  int mon_sym_cyc[$];
  int mon_done_cyc[$];
  int rdy_viol = 0;
  code_t tcode[6];
  len_t  tlen[6];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every emitted symbol and done pulse with the cycle it appeared in.
  always @(negedge clk) begin
    if (bus.sym_valid === 1'b1) begin
      mon_sym.push_back(int'(bus.sym_out));
      mon_sym_cyc.push_back(cyc);
      if (bus.bit_ready !== 1'b0) rdy_viol++;
    end
    if (bus.dec_done === 1'b1) mon_done_cyc.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    mon_sym.delete();
    mon_sym_cyc.delete();
    mon_done_cyc.delete();
    rdy_viol = 0;
  endtask

  task automatic do_reset();
    bus.tbl_valid = 1'b0; bus.tbl_idx = '0; bus.tbl_code = '0; bus.tbl_len = '0;
    bus.tbl_done = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.bit_last = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    clear_mon();
  endtask

  // Writes a stale A1 first (overwritten later); A6 goes in with tbl_done.
  task automatic load_table(input bit drop_a6);
    bus.tbl_valid = 1'b1; bus.tbl_idx = 3'd1; bus.tbl_code = '0; bus.tbl_len = 3'd3;
    idle(1);
    for (int i = 0; i < 6; i++) begin
      bus.tbl_valid = 1'b1;
      bus.tbl_idx   = 3'(i + 1);
      bus.tbl_code  = tcode[i];
      bus.tbl_len   = (drop_a6 && i == 5) ? 3'd0 : tlen[i];
      bus.tbl_done  = (i == 5);
      idle(1);
    end
    bus.tbl_valid = 1'b0; bus.tbl_done = 1'b0; bus.tbl_idx = '0;
  endtask

  task automatic send_bit(input logic b, input logic l);
    int n;
    n = 0;
    while (bus.bit_ready !== 1'b1 && n < 20) begin
      idle(1);
      n++;
    end
    checks++;
    if (bus.bit_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_bit_ready got=%b exp=1 (timeout)", bus.bit_ready);
    end else begin
      bus.bit_valid = 1'b1; bus.bit_in = b; bus.bit_last = l;
      last_acc = cyc;
      idle(1);
      bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.bit_last = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (mon_done_cyc.size() == 0 && k < 30) begin
      idle(1);
      k++;
    end
    checks++;
    if (mon_done_cyc.size() != 1) begin
      failures++;
      $display("FAIL %s_dec_done count got=%0d exp=1", name, mon_done_cyc.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.bit_ready !== 1'b0) begin failures++;
      $display("FAIL reset_bit_ready got=%b exp=0", bus.bit_ready); end
    checks++; if (bus.sym_valid !== 1'b0) begin failures++;
      $display("FAIL reset_sym_valid got=%b exp=0", bus.sym_valid); end
    checks++; if (bus.sym_out !== 3'd0) begin failures++;
      $display("FAIL reset_sym_out got=%0d exp=0", bus.sym_out); end
    checks++; if (bus.dec_done !== 1'b0) begin failures++;
      $display("FAIL reset_dec_done got=%b exp=0", bus.dec_done); end
    checks++; if (bus.err !== 1'b0) begin failures++;
      $display("FAIL reset_err got=%b exp=0", bus.err); end
  endtask

  task automatic test_three_syms();
    logic bits[6];
    int exp_s[3];
    bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_s = '{1, 2, 3};
    do_reset();
    load_table(1'b0);
    for (int i = 0; i < 6; i++) send_bit(bits[i], i == 5);
    wait_done("three");
    checks++;
    if (mon_sym.size() != 3) begin
      failures++;
      $display("FAIL three_count got=%0d exp=3", mon_sym.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (mon_sym[i] != exp_s[i]) begin
          failures++;
          $display("FAIL three_sym[%0d] got=%0d exp=%0d", i, mon_sym[i], exp_s[i]);
        end
      end
      checks++;
      if (mon_done_cyc.size() == 1 && mon_done_cyc[0] != mon_sym_cyc[2] + 1) begin
        failures++;
        $display("FAIL three_done_cycle got=%0d exp=%0d", mon_done_cyc[0], mon_sym_cyc[2] + 1);
      end
    end
    checks++;
    if (bus.bit_ready !== 1'b0) begin
      failures++;
      $display("FAIL three_back_to_load bit_ready got=%b exp=0", bus.bit_ready);
    end
  endtask

  task automatic test_latency();
    logic bits[14];
    int fin[3];
    int exp_s[3];
    bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
             1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_s = '{4, 5, 6};
    do_reset();
    load_table(1'b0);
    for (int i = 0; i < 14; i++) begin
      send_bit(bits[i], i == 13);
      if (i == 3) fin[0] = last_acc;
      if (i == 8) fin[1] = last_acc;
      if (i == 13) fin[2] = last_acc;
    end
    wait_done("latency");
    checks++;
    if (mon_sym.size() != 3) begin
      failures++;
      $display("FAIL latency_count got=%0d exp=3", mon_sym.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (mon_sym[i] != exp_s[i]) begin
          failures++;
          $display("FAIL latency_sym[%0d] got=%0d exp=%0d", i, mon_sym[i], exp_s[i]);
        end
        checks++;
        if (mon_sym_cyc[i] != fin[i] + 2) begin
          failures++;
          $display("FAIL latency_cycle[%0d] got=%0d exp=%0d", i, mon_sym_cyc[i], fin[i] + 2);
        end
      end
    end
  endtask

  task automatic test_gapped();
    logic bits[5];
    bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    load_table(1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(int'($urandom_range(0, 3)));
      send_bit(bits[i], i == 4);
      checks++;
      if (bus.bit_ready !== 1'b0) begin
        failures++;
        $display("FAIL gapped_ready_in_check[%0d] got=%b exp=0", i, bus.bit_ready);
      end
    end
    wait_done("gapped");
    checks++;
    if (mon_sym.size() != 2 || mon_sym[0] != 4 || mon_sym[1] != 1) begin
      failures++;
      $display("FAIL gapped_syms got_count=%0d exp=2 (symbols 4,1)", mon_sym.size());
    end
    checks++;
    if (rdy_viol != 0) begin
      failures++;
      $display("FAIL gapped_ready_in_emit got=%0d exp=0", rdy_viol);
    end
  endtask

  task automatic test_no_match_last();
    logic bits[5];
    bits = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    load_table(1'b1);
    for (int i = 0; i < 5; i++) send_bit(bits[i], i == 4);
`ifdef HUFF_DEC_ERR_EN
    idle(1);
    checks++; if (bus.err !== 1'b1) begin failures++;
      $display("FAIL nomatch_err got=%b exp=1", bus.err); end
    idle(5);
    checks++; if (bus.err !== 1'b1 || bus.bit_ready !== 1'b0) begin failures++;
      $display("FAIL nomatch_hold err=%b ready=%b exp err=1 ready=0", bus.err, bus.bit_ready); end
`else
    wait_done("nomatch");
    checks++; if (bus.err !== 1'b0) begin failures++;
      $display("FAIL nomatch_err got=%b exp=0", bus.err); end
`endif
    checks++;
    if (mon_sym.size() != 0) begin
      failures++;
      $display("FAIL nomatch_syms got=%0d exp=0", mon_sym.size());
    end
  endtask

  task automatic test_maxlen();
    logic bits[7];
    bits = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    load_table(1'b1);
    for (int i = 0; i < 7; i++) send_bit(bits[i], 1'b0);
    idle(1);
`ifdef HUFF_DEC_ERR_EN
    checks++; if (bus.err !== 1'b1 || bus.bit_ready !== 1'b0) begin failures++;
      $display("FAIL maxlen_err err=%b ready=%b exp err=1 ready=0", bus.err, bus.bit_ready); end
    checks++; if (mon_sym.size() != 0) begin failures++;
      $display("FAIL maxlen_syms got=%0d exp=0", mon_sym.size()); end
`else
    checks++; if (bus.bit_ready !== 1'b1) begin failures++;
      $display("FAIL maxlen_back_to_shift got=%b exp=1", bus.bit_ready); end
    send_bit(1'b1, 1'b1);
    wait_done("maxlen");
    checks++;
    if (mon_sym.size() != 1 || mon_sym[0] != 1) begin
      failures++;
      $display("FAIL maxlen_syms got_count=%0d exp=1 (symbol 1)", mon_sym.size());
    end
`endif
  endtask

  task automatic test_short_last();
    do_reset();
    load_table(1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
`ifdef HUFF_DEC_ERR_EN
    idle(1);
    checks++; if (bus.err !== 1'b1) begin failures++;
      $display("FAIL short_err got=%b exp=1", bus.err); end
`else
    wait_done("short");
`endif
    checks++;
    if (mon_sym.size() != 0) begin
      failures++;
      $display("FAIL short_syms got=%0d exp=0", mon_sym.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_table(1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    checks++; if (bus.sym_out !== 3'd1) begin failures++;
      $display("FAIL midreset_pre_sym got=%0d exp=1", bus.sym_out); end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    clear_mon();
    checks++;
    if (bus.bit_ready !== 1'b0 || bus.sym_valid !== 1'b0 || bus.sym_out !== 3'd0 ||
        bus.dec_done !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs rdy=%b sv=%b so=%0d dd=%b err=%b exp all 0",
               bus.bit_ready, bus.sym_valid, bus.sym_out, bus.dec_done, bus.err);
    end
    idle(3);
    checks++; if (bus.bit_ready !== 1'b0) begin failures++;
      $display("FAIL midreset_in_load got=%b exp=0", bus.bit_ready); end
    load_table(1'b0);
    send_bit(1'b1, 1'b1);
    wait_done("midreset");
    checks++;
    if (mon_sym.size() != 1 || mon_sym[0] != 1) begin
      failures++;
      $display("FAIL midreset_sym got_count=%0d exp=1 (symbol 1)", mon_sym.size());
    end
  endtask

  initial begin
    tcode = '{7'd1, 7'd1, 7'd0, 7'd3, 7'd5, 7'd4};
    tlen  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    test_reset();
    test_three_syms();
    test_latency();
    test_gapped();
    test_no_match_last();
    test_maxlen();
    test_short_last();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
